instr_issue: RTL

//   Instruction fetch/issue front end: the sending side of the decoder's instr/instr_valid/next_instr/op_done port.

---
 rtl/instr_issue_if.sv | 37 +++
 rtl/instr_issue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_issue_if
//  Purpose  : Fetch-side and decoder-side signal bundle of the instruction
//             issue front end (instruction memory port, decoder handshake,
//             retire feedback).
//  Revision : 1.0  initial release
// ============================================================================
interface instr_issue_if #(
  parameter int BUS_WIDTH    = 32,
  parameter int OPCODE_WIDTH = 11,
  parameter int IMEM_AW      = 10
) ();
  logic                    imem_req;
  logic [IMEM_AW-1:0]      imem_addr;
  logic                    imem_rvalid;
  logic [BUS_WIDTH-1:0]    imem_rdata;
  logic                    instr_valid;
  logic [BUS_WIDTH-1:0]    instr;
  logic                    next_instr;
  logic                    ex_done;
  logic [OPCODE_WIDTH-1:0] ex_opcode;
  logic [OPCODE_WIDTH-1:0] op_done;

  // Issue unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, op_done,
    input  imem_rvalid, imem_rdata, next_instr, ex_done, ex_opcode
  );

  // Memory / decoder / execute side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op_done,
    output imem_rvalid, imem_rdata, next_instr, ex_done, ex_opcode
  );
endinterface
`default_nettype wire

// File: rtl/instr_issue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_issue
//  Purpose  : Instruction fetch/issue front end. Fetches words from
//             instruction memory (one fetch in flight) into a small FIFO,
//             presents them to the decoder, limits issued-not-retired
//             instructions and reports the last retired opcode.
//  Options  : ISSUE_PERF_EN - adds perf_issued / perf_stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module instr_issue #(
  parameter int BUS_WIDTH       = 32,
  parameter int OPCODE_WIDTH    = 11,
  parameter int IMEM_AW         = 10,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESET_PC        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic [IMEM_AW-1:0] flush_pc,
  output logic               busy,
`ifdef ISSUE_PERF_EN
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_stall,
`endif
  instr_issue_if.master      bus
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_OUT_W-1:0] c_MAX_OUT  = c_OUT_W'(MAX_OUTSTANDING);
  localparam logic [IMEM_AW-1:0] c_RESET_PC = IMEM_AW'(RESET_PC);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_REQ   = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  logic [1:0]              r_state, w_state_next;
  logic [IMEM_AW-1:0]      r_pc;
  logic [BUS_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [c_CNT_W-1:0]      r_count, w_count_next;
  logic [c_OUT_W-1:0]      r_outstanding, w_out_next;
  logic                    r_instr_valid;
  logic [BUS_WIDTH-1:0]    r_instr, w_head_next;
  logic [OPCODE_WIDTH-1:0] r_op_done;
  logic                    w_space, w_req, w_fifo_wr, w_xfer, w_retire;

  // Space is reserved before requesting, so a reply can never hit a full FIFO.
  assign w_space  = (r_count < c_DEPTH);
  assign w_xfer   = r_instr_valid & bus.next_instr;
  assign w_retire = bus.ex_done & (r_outstanding != '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state; a flush with the reply still pending must drain it first
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      c_IDLE:  if (start) w_state_next = c_REQ;
      c_REQ:   if (!flush && w_space) w_state_next = c_WAIT;
      c_WAIT:  begin
        if (flush)                 w_state_next = bus.imem_rvalid ? c_REQ : c_DRAIN;
        else if (bus.imem_rvalid)  w_state_next = c_REQ;
      end
      // Staying in DRAIN on a repeated flush keeps the stale reply from
      // being taken as the answer to a newer request.
      c_DRAIN: if (bus.imem_rvalid) w_state_next = c_REQ;
      default: w_state_next = c_IDLE;
    endcase
  end

  // FSM outputs: fetch request, FIFO write strobe, busy
  always_comb begin
    w_req     = (r_state == c_REQ) && w_space && !flush;
    w_fifo_wr = (r_state == c_WAIT) && bus.imem_rvalid && !flush;
    busy      = (r_state != c_IDLE);
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;

  // Next FIFO occupancy, read pointer, outstanding count and head word
  always_comb begin
    unique case ({w_fifo_wr, w_xfer})
      2'b10:   w_count_next = r_count + c_CNT_W'(1);
      2'b01:   w_count_next = r_count - c_CNT_W'(1);
      default: w_count_next = r_count;
    endcase
    w_rd_ptr_next = r_rd_ptr + c_PTR_W'(w_xfer);
    if (flush) begin
      w_count_next  = '0;
      w_rd_ptr_next = '0;
    end
    w_out_next = r_outstanding;
    if (w_xfer && !w_retire)      w_out_next = r_outstanding + c_OUT_W'(1);
    else if (!w_xfer && w_retire) w_out_next = r_outstanding - c_OUT_W'(1);
    // The word being written becomes the head when it lands in the slot the
    // read pointer will point at (FIFO empty after this cycle's read).
    if (w_fifo_wr && (r_wr_ptr == w_rd_ptr_next)) w_head_next = bus.imem_rdata;
    else                                          w_head_next = r_mem[w_rd_ptr_next];
  end

  // FIFO storage (no reset needed; validity comes from the count)
  always_ff @(posedge clk) begin
    if (w_fifo_wr) r_mem[r_wr_ptr] <= bus.imem_rdata;
  end

  // Fetch PC, FIFO pointers, outstanding count and registered decoder outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= c_RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_op_done     <= '0;
    end else begin
      if (flush)      r_pc <= flush_pc;
      else if (w_req) r_pc <= r_pc + IMEM_AW'(1);
      if (flush)          r_wr_ptr <= '0;
      else if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      r_rd_ptr      <= w_rd_ptr_next;
      r_count       <= w_count_next;
      r_outstanding <= w_out_next;
      r_instr_valid <= (w_count_next != '0) && (w_out_next < c_MAX_OUT);
      if (w_count_next != '0) r_instr <= w_head_next;
      if (bus.ex_done) r_op_done <= bus.ex_opcode;
    end
  end

  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.op_done     = r_op_done;

`ifdef ISSUE_PERF_EN
  logic        w_stall;
  logic [31:0] r_perf_issued, r_perf_stall;

  assign w_stall = ((r_count != '0) && !r_instr_valid) || (r_instr_valid && !bus.next_instr);

  // Saturating event counters; flush does not clear them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_xfer && (r_perf_issued != '1))  r_perf_issued <= r_perf_issued + 32'd1;
      if (w_stall && (r_perf_stall != '1))  r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire
